uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART_TX instance between N_REQ byte-stream requesters. Each requester offers bytes over a valid/ready handshake with a packet "last" marker. The arbiter sequences the transmitter's i_tx_start/i_tx_data/o_tx_done protocol and optionally holds the grant for a whole packet. It sits between protocol/command blocks and the UART_TX instance.

---
 rtl/uart_tx_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX between N_REQ byte-stream requesters,
// with optional packet lock. Define UART_TXARB_WDOG_EN to enable the launch watchdog.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter bit          PKT_LOCK    = 1'b1,
  parameter int unsigned WDOG_CYCLES = 2000000
) (
  input  logic               i_clk,
  input  logic               i_areset,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ*8-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_err
);

  localparam int unsigned IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ must be in 2..8");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("uart_tx_arbiter: WDOG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_DONE
  } state_e;

  state_e             state_q,   state_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [N_REQ-1:0]   grant_q,   grant_d;
  logic               lock_q,    lock_d;
  logic               last_q,    last_d;
  logic [IDX_W-1:0]   rr_ptr_q,  rr_ptr_d;
  logic [IDX_W-1:0]   owner_q,   owner_d;
`ifdef UART_TXARB_WDOG_EN
  logic [31:0]        wdog_q,    wdog_d;
  logic               err_q,     err_d;
`endif

  logic [N_REQ-1:0]   cand;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   scan_idx;
  logic [N_REQ-1:0]   win_onehot;
  logic [7:0]         win_data;
  logic [IDX_W-1:0]   owner_nxt;
  logic               xfer;

  // Rotating search from rr_ptr; a held lock narrows candidates to the owner.
  always_comb begin
    cand      = lock_q ? (i_req_valid & grant_q) : i_req_valid;
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = rr_ptr_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = (scan_idx == IDX_W'(N_REQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  always_comb begin
    win_onehot = '0;
    win_data   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        win_onehot[i] = 1'b1;
        win_data      = i_req_data[8*i +: 8];
      end
    end
  end

  assign owner_nxt   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign o_req_ready = (state_q == ST_IDLE && i_tx_done && win_found) ? win_onehot : '0;
  assign xfer        = |(i_req_valid & o_req_ready);

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    lock_d     = lock_q;
    last_d     = last_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
`ifdef UART_TXARB_WDOG_EN
    wdog_d     = wdog_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          tx_data_d  = win_data;
          last_d     = i_req_last[win_idx];
          grant_d    = win_onehot;
          owner_d    = win_idx;
          tx_start_d = 1'b1;
          state_d    = ST_LAUNCH;
`ifdef UART_TXARB_WDOG_EN
          wdog_d     = '0;
`endif
        end
      end
      ST_LAUNCH: begin
        if (!i_tx_done) begin
          tx_start_d = 1'b0;
          state_d    = ST_WAIT_DONE;
        end
`ifdef UART_TXARB_WDOG_EN
        // Transmitter never acknowledged: drop the byte and release the channel.
        else if (wdog_q == WDOG_CYCLES - 1) begin
          tx_start_d = 1'b0;
          err_d      = 1'b1;
          lock_d     = 1'b0;
          grant_d    = '0;
          rr_ptr_d   = owner_nxt;
          state_d    = ST_IDLE;
        end else begin
          wdog_d     = wdog_q + 32'd1;
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          state_d = ST_IDLE;
          if (PKT_LOCK && !last_q) begin
            lock_d = 1'b1;
          end else begin
            lock_d   = 1'b0;
            grant_d  = '0;
            rr_ptr_d = owner_nxt;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      lock_q     <= 1'b0;
      last_q     <= 1'b0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
`ifdef UART_TXARB_WDOG_EN
      wdog_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      lock_q     <= lock_d;
      last_q     <= last_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
`ifdef UART_TXARB_WDOG_EN
      wdog_q     <= wdog_d;
      err_q      <= err_d;
`endif
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_grant    = grant_q;
  assign o_busy     = (state_q != ST_IDLE) | lock_q;
`ifdef UART_TXARB_WDOG_EN
  assign o_err      = err_q;
`else
  assign o_err      = 1'b0;
`endif

endmodule
